// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
//   Game-state controller for the VGA runner game. A four-state machine
//   (IDLE, RUN, PAUSE, OVER) that changes state only at frame boundaries
//   (falling edge of vs). It also owns the BCD score, the best score and the
//   speed level used by the Ground, Cactus and Jump blocks and by the score
//   renderer.
//
// Ports
//   CLK         system clock
//   RESET       asynchronous, active-high reset
//   start       start/resume button (level; rising edge is the request)
//   pause       pause toggle button (level; rising edge is the request)
//   collision   dinosaur/cactus overlap (level; any high cycle is a request)
//   vs          VGA vertical sync; falling edge marks a frame boundary
//   game_status 0=IDLE, 1=RUN, 2=PAUSE, 3=OVER
//   running     high iff game_status==RUN
//   frame_tick  one-cycle pulse in the cycle after each frame boundary
//   score       BCD score, digit 0 in bits [3:0]
//   high_score  BCD best score since reset
//   speed       current speed level
// ---------------------------------------------------------------------------
module game_ctrl #(
    parameter int SCORE_DIGITS     = 4,
    parameter int FRAMES_PER_POINT = 6,
    parameter int SPEED_STEP       = 100,
    parameter int SPEED_W          = 4,
    parameter int SPEED_MAX        = 15
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      collision,
    input  logic                      vs,
    output logic [1:0]                game_status,
    output logic                      running,
    output logic                      frame_tick,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [4*SCORE_DIGITS-1:0] high_score,
    output logic [SPEED_W-1:0]        speed
);

    localparam int SW   = 4 * SCORE_DIGITS;
    localparam int FC_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam int PT_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

    localparam logic [FC_W-1:0]    FC_LAST   = FC_W'(FRAMES_PER_POINT - 1);
    localparam logic [PT_W-1:0]    PT_LAST   = PT_W'(SPEED_STEP - 1);
    localparam logic [SPEED_W-1:0] SPEED_TOP = SPEED_W'(SPEED_MAX);
    localparam logic [SW-1:0]      SCORE_MAX = {SCORE_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_running;
    logic              r_frame_tick;
    logic [SW-1:0]     r_score;
    logic [SW-1:0]     r_high_score;
    logic [SPEED_W-1:0] r_speed;
    logic [FC_W-1:0]   r_frame_cnt;
    logic [PT_W-1:0]   r_points;
    logic              r_vs_q;
    logic              r_start_q;
    logic              r_pause_q;
    logic              r_start_req;
    logic              r_pause_req;
    logic              r_coll_req;

    state_t            w_next_state;
    logic [SW-1:0]     w_score_nxt;
    logic [SW-1:0]     w_high_nxt;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic [FC_W-1:0]   w_frame_nxt;
    logic [PT_W-1:0]   w_points_nxt;
    logic              w_boundary;
    logic              w_start_edge;
    logic              w_pause_edge;

    // Adds one to a packed BCD value; the caller guarantees it is not all-9s.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] res;
        logic          carry;
        res   = v;
        carry = 1'b1;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    res[4*d +: 4] = 4'd0;
                end else begin
                    res[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign w_boundary   = r_vs_q & ~vs;
    assign w_start_edge = start & ~r_start_q;
    assign w_pause_edge = pause & ~r_pause_q;

    // Next-state and datapath: everything moves only in the boundary cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_next_state = r_state;
        w_score_nxt  = r_score;
        w_high_nxt   = r_high_score;
        w_speed_nxt  = r_speed;
        w_frame_nxt  = r_frame_cnt;
        w_points_nxt = r_points;
        if (w_boundary) begin
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (r_start_req) begin
                        w_next_state = ST_RUN;
                        w_score_nxt  = '0;
                        w_speed_nxt  = SPEED_W'(1);
                        w_frame_nxt  = '0;
                        w_points_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (r_coll_req) begin
                        // Collision beats a simultaneous pause; no scoring this frame.
                        w_next_state = ST_OVER;
                        if (r_score > r_high_score) begin
                            w_high_nxt = r_score;
                        end
                    end else if (r_pause_req) begin
                        w_next_state = ST_PAUSE;
                    end else if (r_frame_cnt == FC_LAST) begin
                        w_frame_nxt = '0;
                        // Saturated score stops the points counter as well.
                        if (r_score != SCORE_MAX) begin
                            w_score_nxt = bcd_inc(r_score);
                            if (r_points == PT_LAST) begin
                                w_points_nxt = '0;
                                if (r_speed != SPEED_TOP) begin
                                    w_speed_nxt = r_speed + SPEED_W'(1);
                                end
                            end else begin
                                w_points_nxt = r_points + PT_W'(1);
                            end
                        end
                    end else begin
                        w_frame_nxt = r_frame_cnt + FC_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (r_start_req || r_pause_req) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_running    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_score      <= '0;
            r_high_score <= '0;
            r_speed      <= '0;
            r_frame_cnt  <= '0;
            r_points     <= '0;
            r_vs_q       <= 1'b1;
            r_start_q    <= 1'b0;
            r_pause_q    <= 1'b0;
            r_start_req  <= 1'b0;
            r_pause_req  <= 1'b0;
            r_coll_req   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state      <= w_next_state;
            r_running    <= (w_next_state == ST_RUN);
            r_frame_tick <= w_boundary;
            r_score      <= w_score_nxt;
            r_high_score <= w_high_nxt;
            r_speed      <= w_speed_nxt;
            r_frame_cnt  <= w_frame_nxt;
            r_points     <= w_points_nxt;
            r_vs_q       <= vs;
            r_start_q    <= start;
            r_pause_q    <= pause;
            // Requests are cleared at each boundary, but an event arriving in
            // the boundary cycle itself survives for the next one.
            r_start_req  <= w_start_edge | (r_start_req & ~w_boundary);
            r_pause_req  <= w_pause_edge | (r_pause_req & ~w_boundary);
            r_coll_req   <= collision    | (r_coll_req  & ~w_boundary);
        end
    end

    assign game_status = r_state;
    assign running     = r_running;
    assign frame_tick  = r_frame_tick;
    assign score       = r_score;
    assign high_score  = r_high_score;
    assign speed       = r_speed;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Parametrised game-state controller for the VGA runner game. It replaces the two-state idle/running flag and start trigger with a four-state machine: IDLE, RUN, PAUSE, OVER. All state changes are applied only at frame boundaries, defined as the falling edge of vs. The block also owns the BCD score, the high score and the speed level, which it supplies to the Ground, Cactus and Jump blocks and to the score renderer.

Parameters:
SCORE_DIGITS, 4, number of BCD digits in score and high_score
FRAMES_PER_POINT, 6, RUN frames per one-point score increment (>=1)
SPEED_STEP, 100, points per speed-level increase (>=1)
SPEED_W, 4, width of speed output
SPEED_MAX, 15, speed saturation value (<= 2^SPEED_W-1, >=1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
start  in  1  start/resume button, active-high level
pause  in  1  pause toggle button, active-high level
collision  in  1  dinosaur/cactus overlap, active-high level
vs  in  1  VGA vertical sync from Vga; falling edge marks frame boundary
game_status  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=OVER
running  out  1  high iff game_status==RUN
frame_tick  out  1  one-cycle pulse, cycle after each frame boundary
score  out  4*SCORE_DIGITS  BCD score, digit 0 in bits [3:0]
high_score  out  4*SCORE_DIGITS  BCD best score since reset
speed  out  SPEED_W  current speed level

Behaviour:
- Reset: asynchronous, active-high; clock and reset are fixed as stated. While RESET is high, all outputs and internal state are cleared: game_status=IDLE, running=0, frame_tick=0, score=0, high_score=0, speed=0, all pending requests=0, frame counter=0, vs_q=1.
- Reset asserted mid-operation: immediate return to IDLE, with high score lost.
- Input edges: start and pause are rising-edge detected against registered copies of themselves.
  - Each detected edge sets a sticky request bit (start_req, pause_req).
  - collision high in any cycle sets collision_req.
- Boundary cycle: the cycle where vs_q==1 and vs==0, with vs_q being vs registered.
  - All transitions below take effect at the end of the boundary cycle.
  - frame_tick is registered high for the following cycle.
  - All three request bits are cleared at every boundary, whether or not they were consumed.
  - A request edge arriving in the boundary cycle itself is kept for the next boundary.
- Transitions (at boundary, in priority order):
  - IDLE: start_req -> RUN; score=0, speed=1, frame counter=0. collision_req and pause_req are ignored.
  - RUN: collision_req -> OVER, taking priority over pause_req. Else pause_req -> PAUSE. Else stay in RUN and advance scoring.
  - PAUSE: start_req or pause_req -> RUN. Score, speed and frame counter are frozen. collision_req is ignored.
  - OVER: start_req -> RUN; score=0, speed=1, frame counter=0. high_score is retained.
- Scoring (RUN-stay boundaries only):
  - Frame counter increments; on reaching FRAMES_PER_POINT it wraps to 0 and score increments by one.
  - BCD carry ripples across digits.
  - score saturates at all-9s; no wrap to 0.
- Speed:
  - A points counter (mod SPEED_STEP) increments with each score increment.
  - On wrap of the points counter, speed increments, saturating at SPEED_MAX.
  - speed is 0 in IDLE after reset, and holds its last value in PAUSE and OVER.
- High score: on the RUN->OVER transition, high_score <= score if score > high_score. BCD magnitude compare equals unsigned compare of the packed vector.
- Simultaneous collision and pause in the same frame while in RUN: OVER wins, and no score increment occurs on that boundary.
- Outputs are registered; running changes in the same cycle as game_status.

Test Plan:
1. Reset release, no vs edges, start pulsed -> game_status stays 0 until the first vs fall. Enters 1 at end of the boundary cycle; speed=1, score=0.
2. RUN with FRAMES_PER_POINT=6 for 60 vs falls -> score=16'h0010, frame_tick pulsed 60 times. With SPEED_STEP=5, speed=3.
3. Pause edge mid-frame -> PAUSE at next boundary. 20 further frames leave score unchanged. Second pause edge -> RUN at the following boundary.
4. collision and pause both asserted in the same frame from RUN with score=16'h0042 and high_score=0 -> game_status=3, high_score=16'h0042. Then start -> RUN with score=0, high_score unchanged.
5. Preload near saturation: run until score=16'h9999, then 12 more frames -> score stays 16'h9999. speed stops at SPEED_MAX=15.
6. RESET asserted asynchronously between clock edges during RUN -> all outputs 0 immediately, without waiting for a clock edge. Start edges during reset are not retained after release.
